// File: rtl/dff_bank_pkg.sv
// Shared types and the round-robin scan helper for the dff_bank_arbiter slice.
package dff_bank_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  // First set bit of req scanning upward from ptr, wrapping at nreq (nreq <= 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input logic [3:0] nreq);
    logic [2:0] win;
    logic       found;
    logic [3:0] idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = {1'b0, ptr} + k[3:0];
      if (idx >= nreq) idx = idx - nreq;
      if (!found && (k[3:0] < nreq) && req[idx[2:0]]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_bank.sv
// DEPTH x W flop storage: async active-low clear, one write port, one registered read port.
module dff_reg_bank #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;
  logic         in_range;

  assign in_range = ({1'b0, addr_i} < DepthW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i && in_range) mem_q[addr_i] <= wdata_i;
      // Out-of-range reads return an all-zero word, which also carries valid parity.
      if (re_i) rdata_q <= in_range ? mem_q[addr_i] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and 3-state sequencer sharing one dff_reg_bank among NREQ requesters.
// Optional stored parity per entry is enabled with the DFF_BANK_PARITY_EN macro.
module dff_bank_arbiter
  import dff_bank_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic               done,
  output logic [DW-1:0]      rdata,
  output logic               perr
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef DFF_BANK_PARITY_EN
  localparam int unsigned BW = DW + 1;
`else
  localparam int unsigned BW = DW;
`endif

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [2:0]        win_q, win_d;
  logic [2:0]        ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [7:0]        req_pad;
  logic [2:0]        win;
  logic [3:0]        nxt;
  logic [BW-1:0]     wword;
  logic [BW-1:0]     rword;
  logic              bank_we, bank_re;

  always_comb begin
    req_pad            = '0;
    req_pad[NREQ-1:0]  = req;
    win                = rr_pick(req_pad, ptr_q, 4'(NREQ));
    nxt                = {1'b0, win_q} + 4'd1;
    state_d            = state_q;
    gnt_d              = gnt_q;
    win_d              = win_q;
    ptr_d              = ptr_q;
    we_d               = we_q;
    addr_d             = addr_q;
    wdata_d            = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d              = StAccess;
          gnt_d                = '0;
          gnt_d[win[IW-1:0]]   = 1'b1;
          win_d                = win;
          we_d                 = we[win[IW-1:0]];
          addr_d               = addr[win*AW +: AW];
          wdata_d              = wdata[win*DW +: DW];
        end
      end
      StAccess: state_d = StResp;
      StResp: begin
        state_d = StIdle;
        gnt_d   = '0;
        ptr_d   = (nxt == 4'(NREQ)) ? 3'd0 : nxt[2:0];
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bank_we = (state_q == StAccess) && we_q;
  assign bank_re = (state_q == StAccess) && !we_q;

`ifdef DFF_BANK_PARITY_EN
  assign wword = {^wdata_q, wdata_q};
  // Flag only read completions; rword still holds the last read during a write's RESP.
  assign perr  = (state_q == StResp) && !we_q && (rword[DW] != (^rword[DW-1:0]));
`else
  assign wword = wdata_q;
  assign perr  = 1'b0;
`endif

  dff_reg_bank #(
    .DEPTH (DEPTH),
    .W     (BW),
    .AW    (AW)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (bank_we),
    .re_i    (bank_re),
    .addr_i  (addr_q),
    .wdata_i (wword),
    .rdata_o (rword)
  );

  assign gnt   = gnt_q;
  assign done  = (state_q == StResp);
  assign rdata = rword[DW-1:0];

endmodule
